// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one fixed-latency FPU multiplier.
// Optional contention counter is enabled by defining FPU_MUL_ARB_PERF_EN.
module fpu_mul_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_DATA = 32,
    parameter int MUL_LAT   = 3,
    parameter int TAG_W     = $clog2(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_a,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_b,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_mul_valid,
    output logic [SIZE_DATA-1:0]           o_mul_a,
    output logic [SIZE_DATA-1:0]           o_mul_b,
    input  logic [SIZE_DATA-1:0]           i_mul_res,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [SIZE_DATA-1:0]           o_rsp_data,
    output logic                           o_busy,
    output logic [15:0]                    o_conflict_cnt
);

    logic [TAG_W-1:0]     ptr_q, ptr_d;
    logic [TAG_W-1:0]     idx;
    logic [TAG_W-1:0]     grant_tag;
    logic                 grant_any;
    logic [NUM_REQ-1:0]   grant;
    logic [SIZE_DATA-1:0] sel_a, sel_b;

    logic                 mul_valid_q;
    logic [SIZE_DATA-1:0] mul_a_q, mul_a_d;
    logic [SIZE_DATA-1:0] mul_b_q, mul_b_d;
    logic [TAG_W-1:0]     mul_tag_q, mul_tag_d;

    logic [MUL_LAT-1:0]   pv_q;
    logic [TAG_W-1:0]     pt_q [MUL_LAT];

    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [SIZE_DATA-1:0] rsp_data_q, rsp_data_d;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        grant     = '0;
        grant_tag = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = TAG_W'((32'(ptr_q) + 32'(i)) % 32'(NUM_REQ));
            if (!grant_any && i_req_valid[idx]) begin
                grant_any = 1'b1;
                grant_tag = idx;
            end
        end
        if (grant_any) grant[grant_tag] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_a = i_req_a[k*SIZE_DATA +: SIZE_DATA];
                sel_b = i_req_b[k*SIZE_DATA +: SIZE_DATA];
            end
        end
    end

    assign ptr_d     = grant_any ? grant_tag : ptr_q;
    assign mul_a_d   = grant_any ? sel_a     : mul_a_q;
    assign mul_b_d   = grant_any ? sel_b     : mul_b_q;
    assign mul_tag_d = grant_any ? grant_tag : mul_tag_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q       <= TAG_W'(NUM_REQ - 1);
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_tag_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mul_valid_q <= grant_any;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_tag_q   <= mul_tag_d;
        end
    end

    // Tag pipeline tracks which requester owns the result emerging from the multiplier.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pv_q <= '0;
            for (int k = 0; k < MUL_LAT; k++) pt_q[k] <= '0;
        end else begin
            pv_q[0] <= mul_valid_q;
            pt_q[0] <= mul_tag_q;
            for (int k = 1; k < MUL_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pt_q[k] <= pt_q[k-1];
            end
        end
    end

    assign rsp_valid_d = pv_q[MUL_LAT-1] ? (NUM_REQ'(1) << pt_q[MUL_LAT-1]) : '0;
    assign rsp_data_d  = pv_q[MUL_LAT-1] ? i_mul_res : rsp_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign o_req_ready = grant;
    assign o_mul_valid = mul_valid_q;
    assign o_mul_a     = mul_a_q;
    assign o_mul_b     = mul_b_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_busy      = mul_valid_q | (|pv_q);

`ifdef FPU_MUL_ARB_PERF_EN
    logic [15:0] conflict_q, conflict_d;
    logic        multi_req;

    assign multi_req  = ($countones(i_req_valid) >= 2);
    assign conflict_d = (multi_req && (conflict_q != 16'hFFFF)) ? conflict_q + 16'd1 : conflict_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) conflict_q <= '0;
        else          conflict_q <= conflict_d;
    end

    assign o_conflict_cnt = conflict_q;
`else
    assign o_conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Randomised and directed bench for fpu_mul_arbiter against a transaction-level reference model.
module tb_fpu_mul_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int SIZE_DATA = 32;
    localparam int MUL_LAT   = 3;
`ifdef FPU_MUL_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                         i_clk = 1'b0;
    logic                         i_rst_n = 1'b0;
    logic [NUM_REQ-1:0]           i_req_valid = '0;
    logic [NUM_REQ*SIZE_DATA-1:0] i_req_a = '0;
    logic [NUM_REQ*SIZE_DATA-1:0] i_req_b = '0;
    logic [SIZE_DATA-1:0]         i_mul_res = '0;
    logic [NUM_REQ-1:0]           o_req_ready;
    logic                         o_mul_valid;
    logic [SIZE_DATA-1:0]         o_mul_a;
    logic [SIZE_DATA-1:0]         o_mul_b;
    logic [NUM_REQ-1:0]           o_rsp_valid;
    logic [SIZE_DATA-1:0]         o_rsp_data;
    logic                         o_busy;
    logic [15:0]                  o_conflict_cnt;

    fpu_mul_arbiter #(.NUM_REQ(NUM_REQ), .SIZE_DATA(SIZE_DATA), .MUL_LAT(MUL_LAT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .o_req_ready(o_req_ready),
        .o_mul_valid(o_mul_valid), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
        .i_mul_res(i_mul_res), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_busy(o_busy), .o_conflict_cnt(o_conflict_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Small positive integers as IEEE singles, so products are exact.
    function automatic logic [31:0] i2f(input int n);
        logic [31:0] nv, mant;
        int e;
        if (n <= 0) return 32'h0;
        nv = 32'(n);
        e = 0;
        for (int j = 0; j < 31; j++) if (nv[j]) e = j;
        mant = (nv << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), mant[22:0]};
    endfunction

    function automatic int f2i(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f[30:23] < 8'd127 || f[30:23] > 8'd135) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'h01, f[22:0]} >> (23 - e);
        return int'(m);
    endfunction

    // Behavioural multiplier: result appears MUL_LAT cycles after the issue strobe.
    logic [31:0] mpipe [MUL_LAT+1] = '{default: 32'h0};
    always @(negedge i_clk) begin
        for (int k = MUL_LAT; k > 0; k--) mpipe[k] = mpipe[k-1];
        mpipe[0] = o_mul_valid ? i2f(f2i(o_mul_a) * f2i(o_mul_b)) : 32'h0;
        i_mul_res = mpipe[MUL_LAT];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {int due; int k; logic [31:0] d;} rsp_t;
    rsp_t        sb[$];
    bit          pend [NUM_REQ];
    int          opa [NUM_REQ];
    int          opb [NUM_REQ];
    int          mptr;
    int          mcnt;
    int          last_hs;
    bit          prev_hs;
    logic [31:0] prev_a, prev_b, last_rsp;

    task automatic model_reset();
        sb.delete();
        for (int k = 0; k < NUM_REQ; k++) pend[k] = 1'b0;
        mptr = NUM_REQ - 1;
        mcnt = 0;
        last_hs = -100;
        prev_hs = 1'b0;
        prev_a = 32'h0;
        prev_b = 32'h0;
        last_rsp = 32'h0;
    endtask

    task automatic post(input int k, input int a, input int b);
        if (!pend[k]) begin
            pend[k] = 1'b1;
            opa[k] = a;
            opb[k] = b;
        end
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] vmask;
        int g, idx;
        @(negedge i_clk);
        vmask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            vmask[k] = pend[k];
            i_req_a[k*SIZE_DATA +: SIZE_DATA] = i2f(opa[k]);
            i_req_b[k*SIZE_DATA +: SIZE_DATA] = i2f(opb[k]);
        end
        i_req_valid = vmask;
        #1;
        g = -1;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (mptr + i) % NUM_REQ;
            if (g < 0 && pend[idx]) g = idx;
        end
        chk("req_ready", 32'(o_req_ready), (g < 0) ? 32'h0 : (32'h1 << g));
        chk("mul_valid", 32'(o_mul_valid), 32'(prev_hs));
        if (prev_hs) begin
            chk("mul_a", o_mul_a, prev_a);
            chk("mul_b", o_mul_b, prev_b);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("rsp_valid", 32'(o_rsp_valid), 32'h1 << sb[0].k);
            last_rsp = sb[0].d;
            void'(sb.pop_front());
        end else begin
            chk("rsp_valid", 32'(o_rsp_valid), 32'h0);
        end
        chk("rsp_data", o_rsp_data, last_rsp);
        chk("busy", 32'(o_busy), 32'((cyc - last_hs) >= 1 && (cyc - last_hs) <= MUL_LAT + 1));
        chk("conflict_cnt", 32'(o_conflict_cnt), 32'(mcnt));
        if (PERF && $countones(vmask) >= 2 && mcnt < 65535) mcnt++;
        prev_hs = (g >= 0);
        if (g >= 0) begin
            prev_a = i2f(opa[g]);
            prev_b = i2f(opb[g]);
            sb.push_back('{cyc + MUL_LAT + 2, g, i2f(opa[g] * opb[g])});
            pend[g] = 1'b0;
            mptr = g;
            last_hs = cyc;
        end
    endtask

    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        i_req_valid = '0;
        #1;
        chk("rst_mul_valid", 32'(o_mul_valid), 32'h0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_cnt", 32'(o_conflict_cnt), 32'h0);
        chk("rst_mul_a", o_mul_a, 32'h0);
        chk("rst_mul_b", o_mul_b, 32'h0);
        chk("rst_rsp_data", o_rsp_data, 32'h0);
        chk("rst_ready", 32'(o_req_ready), 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        for (int i = 0; i < NUM_REQ + MUL_LAT + 4; i++) step();
        chk("drain_empty", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Full contention for 8 cycles from reset: expect grants 0,1,2,3,0,1,2,3.
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < NUM_REQ; k++) post(k, k + 1, c + 2);
            step();
        end
        for (int k = 0; k < NUM_REQ; k++) pend[k] = 1'b0;
        drain();

        // Lone request from requester 2: 2.0 * 3.0.
        post(2, 2, 3);
        step();
        drain();
        chk("single_rsp_data", o_rsp_data, 32'h40C0_0000);

        // Grant 1, then 1&3 contend (3 wins), then wrap to 0 ahead of 1.
        post(1, 5, 7);
        step();
        post(1, 3, 3);
        post(3, 4, 2);
        step();
        post(0, 6, 6);
        step();
        step();
        drain();

        // Random traffic; requesters hold until granted.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NUM_REQ; k++)
                if ($urandom_range(1) == 1) post(k, int'($urandom_range(16, 1)), int'($urandom_range(16, 1)));
            step();
        end
        drain();

        // Reset with three operations in flight, then confirm nothing stale emerges.
        post(1, 2, 2);
        post(2, 3, 3);
        post(3, 4, 4);
        for (int c = 0; c < 3; c++) step();
        do_reset();
        for (int c = 0; c < 10; c++) step();
        for (int k = 0; k < NUM_REQ; k++) post(k, k + 2, 3);
        step();
        for (int k = 0; k < NUM_REQ; k++) pend[k] = 1'b0;
        drain();

        // Idle window.
        for (int c = 0; c < 10; c++) step();

        // Long contention run: saturation with the counter enabled, stays 0 without.
`ifdef FPU_MUL_ARB_PERF_EN
        for (int c = 0; c < 70000; c++) begin
`else
        for (int c = 0; c < 300; c++) begin
`endif
            for (int k = 0; k < NUM_REQ; k++) post(k, 1 + (c % 16), 1 + k);
            step();
        end
        for (int k = 0; k < NUM_REQ; k++) pend[k] = 1'b0;
        drain();
        chk("final_cnt", 32'(o_conflict_cnt), PERF ? 32'h0000_FFFF : 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpu_mul_arbiter.md
FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 4, is the number of requesters sharing one FPU multiplier; legal range 2..8.
REQ-002: Parameter SIZE_DATA, default 32, is the IEEE-754 single operand/result width.
REQ-003: Parameter MUL_LAT, default 3, is the fixed multiplier latency in cycles from issue to result; legal range 1..8.
REQ-004: Parameter TAG_W, default $clog2(NUM_REQ), is the requester-tag width.
REQ-005: i_clk  input  1  sole clock, rising edge.
REQ-006: i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007: i_req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-008: i_req_a, i_req_b  input  NUM_REQ*SIZE_DATA each  packed operands; requester k occupies bits [k*SIZE_DATA +: SIZE_DATA].
REQ-009: o_req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
REQ-010: o_mul_valid  output  1  issue strobe to the multiplier.
REQ-011: o_mul_a, o_mul_b  output  SIZE_DATA  operands of the granted requester.
REQ-012: i_mul_res  input  SIZE_DATA  multiplier result, valid exactly MUL_LAT cycles after the matching o_mul_valid.
REQ-013: o_rsp_valid  output  NUM_REQ  one-hot result strobe to the owning requester.
REQ-014: o_rsp_data  output  SIZE_DATA  result, shared by all requesters.
REQ-015: o_busy  output  1  high while any issued operation is outstanding.
REQ-016: o_conflict_cnt  output  16  contention counter (see Configuration).

Function
REQ-017: The block SHALL grant at most one requester per cycle, round-robin, searching upward from (last granted index + 1) mod NUM_REQ.
REQ-018: o_req_ready SHALL be combinational from i_req_valid and the round-robin pointer, and SHALL be all-zero when no valid is high.
REQ-019: The grant SHALL NOT depend on a requester's own ready; a valid requester holds its operands until granted.
REQ-020: On a grant, the pointer SHALL update to the granted index at the next rising edge; with no grant it SHALL hold.
REQ-021: o_mul_valid, o_mul_a and o_mul_b SHALL be registered, asserting one cycle after the handshake (issue latency 1).
REQ-022: The block SHALL carry {valid, tag} through a MUL_LAT-deep shift register aligned to o_mul_valid.
REQ-023: o_rsp_valid and o_rsp_data SHALL be registered, asserting one cycle after i_mul_res is sampled; total latency from handshake to o_rsp_valid is MUL_LAT+2 cycles.
REQ-024: o_rsp_valid SHALL be the one-hot decode of the emerging tag when the emerging valid is high, else zero; o_rsp_data SHALL hold its previous value when no response is emitted.
REQ-025: Responses SHALL have no backpressure; requesters SHALL accept o_rsp_valid unconditionally.
REQ-026: Back-to-back issue every cycle SHALL be sustained; an issue and a response in the same cycle SHALL both complete.
REQ-027: o_busy SHALL be the OR of o_mul_valid and all tag-pipeline valids.
REQ-028: Pointer wrap-around: after granting NUM_REQ-1, the search SHALL start at 0.

Reset
REQ-029: While i_rst_n is low, o_mul_valid, o_rsp_valid, o_busy, the tag-pipeline valids and o_conflict_cnt SHALL be 0; o_mul_a, o_mul_b and o_rsp_data SHALL be 0; the pointer SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-030: Reset asserted mid-operation SHALL discard all in-flight operations; no o_rsp_valid SHALL appear for operations issued before reset.

Configuration
REQ-031: With macro FPU_MUL_ARB_PERF_EN defined, o_conflict_cnt SHALL increment by 1 on each cycle in which two or more i_req_valid bits are high, saturating at 16'hFFFF.
REQ-032: Without FPU_MUL_ARB_PERF_EN, o_conflict_cnt SHALL be constant 0, no counter logic SHALL be synthesized, and the port SHALL remain present.

Verification
REQ-033: Single request: requester 2 presents a=0x40000000 and b=0x40400000 for 1 cycle; with a model multiplier at MUL_LAT=3, o_rsp_valid=4'b0100 and o_rsp_data=0x40C00000 exactly 5 cycles after the handshake.
REQ-034: All 4 requesters held valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3 with one grant per cycle, and 8 responses in the same order; with PERF_EN, o_conflict_cnt=8.
REQ-035: Requesters 1 and 3 valid, last grant=1 -> requester 3 is granted next, then 1; the pointer wraps correctly from 3 to 0.
REQ-036: Reset is pulsed low asynchronously while 3 operations are in flight -> outputs clear immediately, no stale o_rsp_valid follows, and the first post-reset grant goes to requester 0.
REQ-037: Saturation, PERF_EN only: force 70000 contention cycles -> o_conflict_cnt=0xFFFF and it holds there; without the macro it stays 0.
REQ-038: Idle: no valid for 10 cycles -> o_req_ready=0, o_mul_valid=0, and o_busy deasserts MUL_LAT+1 cycles after the last issue.
